// File: rtl/m_ext_pkg.sv
// Shared M-extension multiply types: opcode and sequencer state encodings,
// plus operand-signedness decode helpers.
package m_ext_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } mul_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } mul_state_t;

  localparam int MUL_LAT_MAX = 15;

  // rs1 is signed for everything except MULHU
  function automatic logic op_sa(input mul_op_t op);
    return op != OP_MULHU;
  endfunction

  // rs2 is signed only for MUL and MULH
  function automatic logic op_sb(input mul_op_t op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

  function automatic logic op_low_half(input mul_op_t op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Request / core / response bundle of the multiply sequencer. The slave
// modport is the sequencer; master is the pipeline + core side.
interface mul_seq_ctrl_if import m_ext_pkg::*; #(
  parameter int WIDTH = 32
);
  logic               flush_i;
  logic               req_valid_i;
  logic               req_ready_o;
  mul_op_t            req_op_i;
  logic [WIDTH-1:0]   rs1_i;
  logic [WIDTH-1:0]   rs2_i;
  logic               core_valid_o;
  logic [WIDTH-1:0]   core_a_o;
  logic [WIDTH-1:0]   core_b_o;
  logic [2*WIDTH-1:0] core_prod_i;
  logic               resp_valid_o;
  logic               resp_ready_i;
  logic [WIDTH-1:0]   resp_data_o;
  logic               busy_o;

  modport slave (
    input  flush_i, req_valid_i, req_op_i, rs1_i, rs2_i, core_prod_i, resp_ready_i,
    output req_ready_o, core_valid_o, core_a_o, core_b_o, resp_valid_o, resp_data_o, busy_o
  );

  modport master (
    output flush_i, req_valid_i, req_op_i, rs1_i, rs2_i, core_prod_i, resp_ready_i,
    input  req_ready_o, core_valid_o, core_a_o, core_b_o, resp_valid_o, resp_data_o, busy_o
  );
endinterface

// File: rtl/mul_seq_ctrl_operand_cond.sv
// Operand conditioning: per-op signedness, unsigned magnitudes and the
// product negate flag. Purely combinational.
module mul_operand_cond import m_ext_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  mul_op_t          op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic [WIDTH-1:0] mag_a,
  output logic [WIDTH-1:0] mag_b,
  output logic             neg
);
  logic na, nb;

  assign na = op_sa(op) & rs1[WIDTH-1];
  assign nb = op_sb(op) & rs2[WIDTH-1];

  // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude
  assign mag_a = na ? -rs1 : rs1;
  assign mag_b = nb ? -rs2 : rs2;
  assign neg   = na ^ nb;
endmodule

// File: rtl/mul_seq_ctrl.sv
// M-extension multiply sequencer: launches the fixed-latency core, times its
// result, applies sign correction. `MUL_OPCACHE_EN adds a one-entry result cache.
module mul_seq_ctrl import m_ext_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 4
) (
  input  logic           clk,
  input  logic           rst,
  mul_seq_ctrl_if.slave  bus
);
  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_LAUNCH = ST_LAUNCH;
  localparam logic [1:0] S_WAIT   = ST_WAIT;
  localparam logic [1:0] S_DONE   = ST_DONE;
  localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

  logic [1:0]         state;
  logic [3:0]         cnt;
  logic               neg_q;
  logic               low_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               neg;
  logic               accept;

  mul_operand_cond #(.WIDTH(WIDTH)) u_cond (
    .op    (bus.req_op_i),
    .rs1   (bus.rs1_i),
    .rs2   (bus.rs2_i),
    .mag_a (mag_a),
    .mag_b (mag_b),
    .neg   (neg)
  );

  assign bus.req_ready_o  = ~rst & (state == S_IDLE) & ~bus.flush_i;
  assign accept           = bus.req_valid_i & bus.req_ready_o;
  assign bus.core_valid_o = (state == S_LAUNCH);
  assign bus.core_a_o     = a_q;
  assign bus.core_b_o     = b_q;
  assign bus.resp_valid_o = (state == S_DONE);
  assign bus.resp_data_o  = low_q ? prod_q[WIDTH-1:0] : prod_q[2*WIDTH-1:WIDTH];
  assign bus.busy_o       = (state != S_IDLE);
  assign prod_fix         = neg_q ? -bus.core_prod_i : bus.core_prod_i;

`ifdef MUL_OPCACHE_EN
  localparam int KW = 2*WIDTH + 2;
  logic               c_vld;
  logic [KW-1:0]      c_key, key_q, key_d;
  logic [2*WIDTH-1:0] c_prod;
  logic               hit;

  // op half-select is not part of the key, so MULH then MUL on the same operands hits
  assign key_d = {bus.rs1_i, bus.rs2_i, op_sa(bus.req_op_i), op_sb(bus.req_op_i)};
  assign hit   = c_vld & (c_key == key_d);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      neg_q  <= 1'b0;
      low_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
`ifdef MUL_OPCACHE_EN
      c_vld  <= 1'b0;
      c_key  <= '0;
      key_q  <= '0;
      c_prod <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          neg_q <= neg;
          low_q <= op_low_half(bus.req_op_i);
          a_q   <= mag_a;
          b_q   <= mag_b;
`ifdef MUL_OPCACHE_EN
          key_q <= key_d;
          if (hit) begin
            prod_q <= c_prod;
            state  <= S_DONE;
          end else begin
            state  <= S_LAUNCH;
          end
`else
          state <= S_LAUNCH;
`endif
        end
        S_LAUNCH: if (bus.flush_i) begin
          state <= S_IDLE;
        end else begin
          cnt   <= CNT_LOAD;
          state <= S_WAIT;
        end
        // sampling is purely counter-timed, so a flushed op's late product is never seen
        S_WAIT: if (bus.flush_i) begin
          state <= S_IDLE;
        end else if (cnt == 4'd0) begin
          prod_q <= prod_fix;
          state  <= S_DONE;
`ifdef MUL_OPCACHE_EN
          c_vld  <= 1'b1;
          c_key  <= key_q;
          c_prod <= prod_fix;
`endif
        end else begin
          cnt <= cnt - 4'd1;
        end
        S_DONE: if (bus.flush_i | bus.resp_ready_i) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
